// File: rtl/hazard_forward_ctrl.sv
// Forwarding-select and load-use stall controller for the five-stage MIPS core.
// Tracks its own EX/MEM/WB destination records so outputs never depend on datapath registers.

module hfc_fwd_sel #(
  parameter int NRegBits = 5
) (
  input  logic [NRegBits-1:0] src_i,
  input  logic                ex_vld_i,
  input  logic                mem_hit_en_i,
  input  logic [NRegBits-1:0] mem_wr_i,
  input  logic                wb_hit_en_i,
  input  logic [NRegBits-1:0] wb_wr_i,
  output logic [1:0]          sel_o
);
  always_comb begin
    sel_o = 2'b00;
    if (ex_vld_i) begin
      if (mem_hit_en_i && (mem_wr_i == src_i))     sel_o = 2'b10;
      else if (wb_hit_en_i && (wb_wr_i == src_i))  sel_o = 2'b01;
    end
  end
endmodule

module hazard_forward_ctrl #(
  parameter int NRegBits  = 5,
  parameter int CountBits = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRegBits-1:0]  ID_Rs,
  input  logic [NRegBits-1:0]  ID_Rt,
  input  logic [NRegBits-1:0]  ID_WriteReg,
  input  logic                 ID_RegWrite,
  input  logic                 ID_MemRead,
  input  logic                 ID_Valid,
  input  logic                 Flush,
  output logic [1:0]           ForwardA,
  output logic [1:0]           ForwardB,
  output logic                 Stall,
  output logic                 Bubble,
  output logic [CountBits-1:0] StallCount
);
  typedef struct packed {
    logic [NRegBits-1:0] rs;
    logic [NRegBits-1:0] rt;
    logic [NRegBits-1:0] wr;
    logic                rw;
    logic                mr;
    logic                vld;
  } ex_rec_t;

  typedef struct packed {
    logic [NRegBits-1:0] wr;
    logic                rw;
    logic                mr;
    logic                vld;
  } mem_rec_t;

  typedef struct packed {
    logic [NRegBits-1:0] wr;
    logic                rw;
    logic                vld;
  } wb_rec_t;

  typedef enum logic {RUN, HOLD} state_t;

  ex_rec_t              ex_q, ex_d;
  mem_rec_t             mem_q;
  wb_rec_t              wb_q;
  state_t               state_q, state_d;
  logic [CountBits-1:0] cnt_q, cnt_d;
  logic                 load_use, stall_c;
  logic                 mem_hit_en, wb_hit_en;
  logic [1:0][NRegBits-1:0] fwd_src;
  logic [1:0][1:0]          fwd_sel;

  assign mem_hit_en = mem_q.vld && mem_q.rw && !mem_q.mr && (mem_q.wr != '0);
  assign wb_hit_en  = wb_q.vld && wb_q.rw && (wb_q.wr != '0);
  assign fwd_src    = {ex_q.rt, ex_q.rs};

  // One selector per EX operand: index 0 is A (rs), index 1 is B (rt)
  for (genvar g = 0; g < 2; g++) begin : g_fwd
    hfc_fwd_sel #(.NRegBits(NRegBits)) u_sel (
      .src_i        (fwd_src[g]),
      .ex_vld_i     (ex_q.vld),
      .mem_hit_en_i (mem_hit_en),
      .mem_wr_i     (mem_q.wr),
      .wb_hit_en_i  (wb_hit_en),
      .wb_wr_i      (wb_q.wr),
      .sel_o        (fwd_sel[g])
    );
  end

  assign ForwardA = fwd_sel[0];
  assign ForwardB = fwd_sel[1];

  assign load_use = ID_Valid && ex_q.vld && ex_q.mr && ex_q.rw && (ex_q.wr != '0) &&
                    ((ex_q.wr == ID_Rs) || (ex_q.wr == ID_Rt));

  always_comb begin
    state_d = RUN;
    stall_c = 1'b0;
    case (state_q)
      RUN: begin
        stall_c = load_use && !Flush;
        if (stall_c) state_d = HOLD;
      end
      HOLD:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Reset also silences the combinational outputs while it is held
  assign Stall  = reset && stall_c;
  assign Bubble = reset && (stall_c || Flush);

  always_comb begin
    ex_d     = ex_q;
    ex_d.vld = 1'b0;
    if (!Bubble) begin
      ex_d.rs  = ID_Rs;
      ex_d.rt  = ID_Rt;
      ex_d.wr  = ID_WriteReg;
      ex_d.rw  = ID_RegWrite;
      ex_d.mr  = ID_MemRead;
      ex_d.vld = ID_Valid;
    end
    cnt_d = cnt_q;
    if (Stall && (cnt_q != '1)) cnt_d = cnt_q + CountBits'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= '{wr: ex_q.wr, rw: ex_q.rw, mr: ex_q.mr, vld: ex_q.vld};
      wb_q    <= '{wr: mem_q.wr, rw: mem_q.rw, vld: mem_q.vld};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign StallCount = cnt_q;
endmodule
